tr_strobe_sched: RTL and testbench
==================================

# tr_strobe_sched

Strobe scheduler between the Avalon-MM command register block and `TR_P`. Single-cycle commands from the register block go in. Precisely timed `start`, `start_N` and `stop` strobes come out to `TR_P`. The block supports three sequences: single pulse, N-pulse burst, and free-running auto mode, each with a programmable start delay and pulse spacing.

## Interface
Parameters:
- `CNT_W`, 32: width of delay and period counters.
- `N_W`, 16: width of the burst count and the pulse counter.

Ports:
- `clk` in 1: system clock, 50 MHz. One clock domain only.
- `rst` in 1: reset, synchronous and active-high.
- `cfg_delay` in CNT_W: cycles from command to first pulse.
- `cfg_period` in CNT_W: spacing between pulses; actual spacing is `cfg_period+1` cycles.
- `cfg_count` in N_W: pulses per burst.
- `cmd_start` in 1: one-cycle strobe requesting a single pulse.
- `cmd_start_N` in 1: one-cycle strobe requesting a burst.
- `cmd_stop` in 1: one-cycle strobe requesting an abort.
- `avto` in 1: one-cycle strobe arming auto (free-run) mode.
- `start` out 1: one-cycle pulse to `TR_P` (single and auto modes).
- `start_N` out 1: one-cycle pulse to `TR_P` (burst mode).
- `stop` out 1: one-cycle end-of-sequence or abort strobe to `TR_P`.
- `busy` out 1: high from command accept until the sequence ends.
- `pulse_cnt` out N_W: pulses emitted in the current or last sequence.
- `ovr` out 1: sticky flag, set when a command arrives while busy.

## Operation
- States: IDLE, DELAY, FIRE, WAIT.
- Command accept:
  - Commands are accepted in IDLE only.
  - Priority when several commands are high in the same cycle: `cmd_stop` > `cmd_start_N` > `cmd_start` > `avto`.
  - On accept, `cfg_*` are latched, `pulse_cnt` clears to 0 and `ovr` clears to 0.
- Modes and pulse counts:
  - `cmd_start` selects SINGLE mode: remaining = 1.
  - `cmd_start_N` selects BURST mode: remaining = `cfg_count`. With `cfg_count`=0 the command is ignored: no state change, no strobes.
  - `avto` selects AUTO mode: no terminal count.
- DELAY:
  - The counter loads `cfg_delay` and decrements each cycle.
  - At 0 the state moves to FIRE.
  - With `cfg_delay`=0, DELAY is skipped and the state goes directly to FIRE.
- FIRE (one cycle):
  - Asserts `start` in SINGLE/AUTO mode, or `start_N` in BURST mode.
  - Increments `pulse_cnt`, saturating at all-ones, and decrements remaining.
  - If remaining reaches 0 (not AUTO): go to IDLE.
  - Otherwise: load `cfg_period` into the counter and go to WAIT, or go back to FIRE directly if `cfg_period`=0.
- WAIT: the counter decrements; at 0 the state moves to FIRE.
- Normal completion: `stop` pulses the cycle after the final pulse, and `busy` drops in that same cycle.
- `cmd_stop` while busy, in any state:
  - Aborts the sequence and returns to IDLE.
  - `stop` pulses the next cycle.
  - No further `start`/`start_N` pulses are issued; `pulse_cnt` holds its value.
- `cmd_stop` in IDLE: passed through as a `stop` pulse one cycle later.
- `cmd_start`, `cmd_start_N` or `avto` while busy: ignored, and `ovr` is set.
- `cmd_stop` in the same cycle as FIRE: the pulse already in FIRE is still emitted, then `stop` follows on the next cycle and no more pulses are issued.
- Reset:
  - All outputs are 0 after reset: `start`, `start_N`, `stop`, `busy`, `pulse_cnt`, `ovr`.
  - State after reset is IDLE.
  - `rst` mid-sequence: no strobe is emitted in the cycle following reset.

## Timing
- All outputs are registered.
- First pulse is high in the cycle `cfg_delay+1` cycles after the command cycle.
- Consecutive pulses are exactly `cfg_period+1` cycles apart, rising edge to rising edge.
- `stop` latency is 1 cycle from the final pulse or from `cmd_stop`.
- `busy` is high from the cycle after accept through the final-pulse cycle.
- `start`, `start_N` and `stop` are never high in the same cycle.

## Configuration
- `TR_SCHED_AUTO_EN` defined: `avto` arms AUTO mode as described in Operation.
- `TR_SCHED_AUTO_EN` undefined:
  - `avto` is ignored: no accept, no `ovr`.
  - The AUTO mode logic is not compiled in.
  - The port remains, so the top level is unchanged.

## Structure
- Package `tr_pkg` holds:
  - the state enum (IDLE/DELAY/FIRE/WAIT);
  - the mode enum (SINGLE/BURST/AUTO);
  - the default `CNT_W`/`N_W` constants.
- Sub-module `tr_down_counter`: loadable CNT_W down counter with a `zero` flag. It is shared by DELAY and WAIT, and one instance is sufficient.

## Test plan
- Single pulse: `cfg_delay`=5, then `cmd_start` at cycle 100 → `start` high at cycle 106 only; `stop` at 107; `pulse_cnt`=1.
- Burst: `cfg_delay`=0, `cfg_period`=3, `cfg_count`=4, `cmd_start_N` at cycle 10 → `start_N` at 11, 15, 19, 23; `stop` at 24; `pulse_cnt`=4.
- Auto plus abort: `cfg_period`=9, `avto` at cycle 0, `cmd_stop` at cycle 35 → `start` at 1, 11, 21, 31; `stop` at 36; nothing after.
- Busy overrun: `cmd_start` during a burst → pulse train unchanged, `ovr`=1; the next accepted command clears `ovr`.
- Simultaneous commands: `cmd_stop` and `cmd_start_N` in the same IDLE cycle → `stop` next cycle only, `busy` stays 0. Separately, `cmd_start_N` with `cfg_count`=0 → no activity.
- Reset mid-burst: `rst` during WAIT → all outputs 0 the next cycle; after release a new `cmd_start` runs normally.

Source files
------------

// File: rtl/tr_pkg.sv
// Shared types and default widths for the TR_P strobe scheduler.
package tr_pkg;

  localparam int unsigned TR_CNT_W = 32;
  localparam int unsigned TR_N_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    FIRE,
    WAIT
  } tr_state_t;

  typedef enum logic [1:0] {
    SINGLE,
    BURST,
    AUTO
  } tr_mode_t;

endpackage

// File: rtl/tr_down_counter.sv
// Loadable down counter shared by the DELAY and WAIT phases.
// Holds at zero once it gets there; zero flag reflects the current count.
module tr_down_counter
  import tr_pkg::*;
#(
  parameter int unsigned CNT_W = TR_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load has priority over counting; stop decrementing at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tr_strobe_sched.sv
// Strobe scheduler: turns single-cycle register-block commands into timed
// start / start_N / stop strobes for TR_P.
// Build option: define TR_SCHED_AUTO_EN to compile in the free-running
// AUTO mode armed by avto; otherwise avto is ignored.
module tr_strobe_sched
  import tr_pkg::*;
#(
  parameter int unsigned CNT_W = TR_CNT_W,
  parameter int unsigned N_W   = TR_N_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [N_W-1:0]   cfg_count,
  input  logic             cmd_start,
  input  logic             cmd_start_N,
  input  logic             cmd_stop,
  input  logic             avto,
  output logic             start,
  output logic             start_N,
  output logic             stop,
  output logic             busy,
  output logic [N_W-1:0]   pulse_cnt,
  output logic             ovr
);

  tr_state_t        state, state_nxt;
  tr_mode_t         mode_q, mode_nxt;
  logic [N_W-1:0]   remaining;
  logic [CNT_W-1:0] period_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             accept;
  logic             ovr_hit;
  logic             stop_nxt;
  logic             last;
  logic             req_hit;

`ifdef TR_SCHED_AUTO_EN
  assign req_hit = cmd_start | cmd_start_N | avto;
`else
  logic unused_avto;
  assign unused_avto = avto;
  assign req_hit     = cmd_start | cmd_start_N;
`endif

  tr_down_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_val),
    .zero    (cnt_zero)
  );

  // Next-state, command accept and abort decode.
  // Counter is loaded one short (N-1) so the FIRE state, and the registered
  // strobe that tracks it, lands exactly N+1 cycles after the load cycle.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    accept    = 1'b0;
    ovr_hit   = 1'b0;
    stop_nxt  = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_stop) begin
          stop_nxt = 1'b1;
        end else if (cmd_start_N) begin
          if (cfg_count != '0) begin
            accept   = 1'b1;
            mode_nxt = BURST;
          end
        end else if (cmd_start) begin
          accept   = 1'b1;
          mode_nxt = SINGLE;
        end
`ifdef TR_SCHED_AUTO_EN
        else if (avto) begin
          accept   = 1'b1;
          mode_nxt = AUTO;
        end
`endif
        if (accept) begin
          if (cfg_delay == '0) begin
            state_nxt = FIRE;
          end else begin
            state_nxt = DELAY;
            cnt_load  = 1'b1;
            cnt_val   = cfg_delay - CNT_W'(1);
          end
        end
      end
      DELAY: begin
        if (cnt_zero) state_nxt = FIRE;
      end
      FIRE: begin
`ifdef TR_SCHED_AUTO_EN
        last = (mode_q != AUTO) && (remaining == N_W'(1));
`else
        last = (remaining == N_W'(1));
`endif
        if (last) begin
          state_nxt = IDLE;
          stop_nxt  = 1'b1;
        end else if (period_q == '0) begin
          state_nxt = FIRE;
        end else begin
          state_nxt = WAIT;
          cnt_load  = 1'b1;
          cnt_val   = period_q - CNT_W'(1);
        end
      end
      WAIT: begin
        if (cnt_zero) state_nxt = FIRE;
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE) begin
      ovr_hit = req_hit;
      if (cmd_stop) begin
        state_nxt = IDLE;
        stop_nxt  = 1'b1;
        cnt_load  = 1'b0;
      end
    end
  end

  // State, sequence bookkeeping and registered outputs.
  // Strobes are registered from the next state so they coincide with FIRE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= SINGLE;
      remaining <= '0;
      period_q  <= '0;
      start     <= 1'b0;
      start_N   <= 1'b0;
      stop      <= 1'b0;
      busy      <= 1'b0;
      pulse_cnt <= '0;
      ovr       <= 1'b0;
    end else begin
      state   <= state_nxt;
      mode_q  <= mode_nxt;
      start   <= (state_nxt == FIRE) && (mode_nxt != BURST);
      start_N <= (state_nxt == FIRE) && (mode_nxt == BURST);
      stop    <= stop_nxt;
      busy    <= (state_nxt != IDLE);
      if (accept) begin
        remaining <= (mode_nxt == BURST) ? cfg_count : N_W'(1);
        period_q  <= cfg_period;
        pulse_cnt <= '0;
        ovr       <= 1'b0;
      end else begin
        if (state == FIRE) begin
          if (remaining != '0) remaining <= remaining - N_W'(1);
          if (pulse_cnt != '1) pulse_cnt <= pulse_cnt + N_W'(1);
        end
        if (ovr_hit) ovr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tr_strobe_sched.sv
// Directed bench for tr_strobe_sched with hand-computed strobe timing masks.
// Bit k of each history mask is the output value k cycles after the
// command cycle plus one, i.e. bit 0 is the cycle right after the command.
module tb_tr_strobe_sched;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned N_W   = 16;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_period;
  logic [N_W-1:0]   cfg_count;
  logic             cmd_start;
  logic             cmd_start_N;
  logic             cmd_stop;
  logic             avto;
  logic             start;
  logic             start_N;
  logic             stop;
  logic             busy;
  logic [N_W-1:0]   pulse_cnt;
  logic             ovr;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  logic [63:0] h_start, h_start_n, h_stop, h_busy;

  tr_strobe_sched #(
    .CNT_W(CNT_W),
    .N_W  (N_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_delay  (cfg_delay),
    .cfg_period (cfg_period),
    .cfg_count  (cfg_count),
    .cmd_start  (cmd_start),
    .cmd_start_N(cmd_start_N),
    .cmd_stop   (cmd_stop),
    .avto       (avto),
    .start      (start),
    .start_N    (start_N),
    .stop       (stop),
    .busy       (busy),
    .pulse_cnt  (pulse_cnt),
    .ovr        (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // cmd / inj bit order: {avto, cmd_stop, cmd_start_N, cmd_start}
  task automatic run(input logic [3:0] cmd, input int unsigned n,
                     input int unsigned inj_k, input logic [3:0] inj);
    {avto, cmd_stop, cmd_start_N, cmd_start} = cmd;
    step();
    {avto, cmd_stop, cmd_start_N, cmd_start} = '0;
    h_start   = '0;
    h_start_n = '0;
    h_stop    = '0;
    h_busy    = '0;
    for (int unsigned k = 0; k < n; k++) begin
      h_start[k]   = start;
      h_start_n[k] = start_N;
      h_stop[k]    = stop;
      h_busy[k]    = busy;
      if (k == inj_k) {avto, cmd_stop, cmd_start_N, cmd_start} = inj;
      step();
      {avto, cmd_stop, cmd_start_N, cmd_start} = '0;
    end
  endtask

  initial begin
    rst         = 1'b1;
    cfg_delay   = '0;
    cfg_period  = '0;
    cfg_count   = '0;
    cmd_start   = 1'b0;
    cmd_start_N = 1'b0;
    cmd_stop    = 1'b0;
    avto        = 1'b0;
    step();
    step();
    chk("rst_strobes", {61'd0, start, start_N, stop}, 64'd0);
    chk("rst_busy_ovr", {62'd0, busy, ovr}, 64'd0);
    chk("rst_pulse_cnt", 64'(pulse_cnt), 64'd0);
    rst = 1'b0;
    step();

    // Single pulse, delay 5: start 6 cycles after command, stop one later.
    cfg_delay = 5;
    run(4'b0001, 20, 999, 4'b0000);
    chk("single_start", h_start, 64'h20);
    chk("single_stop", h_stop, 64'h40);
    chk("single_start_n", h_start_n, 64'h0);
    chk("single_busy", h_busy, 64'h3F);
    chk("single_cnt", 64'(pulse_cnt), 64'd1);

    // Burst: delay 0, period 3, count 4.
    cfg_delay  = 0;
    cfg_period = 3;
    cfg_count  = 4;
    run(4'b0010, 24, 999, 4'b0000);
    chk("burst_start_n", h_start_n, 64'h1111);
    chk("burst_stop", h_stop, 64'h2000);
    chk("burst_busy", h_busy, 64'h1FFF);
    chk("burst_start", h_start, 64'h0);
    chk("burst_cnt", 64'(pulse_cnt), 64'd4);

    // Overrun: cmd_start injected during a burst.
    run(4'b0010, 24, 2, 4'b0001);
    chk("ovr_train", h_start_n, 64'h1111);
    chk("ovr_stop", h_stop, 64'h2000);
    chk("ovr_set", 64'(ovr), 64'd1);

    // Next accepted command clears ovr.
    cfg_delay = 0;
    run(4'b0001, 8, 999, 4'b0000);
    chk("ovr_clear", 64'(ovr), 64'd0);
    chk("ovr_clear_start", h_start, 64'h1);

    // Stop and start_N together in IDLE: stop only.
    cfg_count = 4;
    run(4'b0110, 10, 999, 4'b0000);
    chk("simul_stop", h_stop, 64'h1);
    chk("simul_busy", h_busy, 64'h0);
    chk("simul_start_n", h_start_n, 64'h0);

    // start_N with count 0: ignored.
    cfg_count = 0;
    run(4'b0010, 10, 999, 4'b0000);
    chk("cnt0_start_n", h_start_n, 64'h0);
    chk("cnt0_busy", h_busy, 64'h0);
    chk("cnt0_stop", h_stop, 64'h0);

    // Abort in FIRE: delay 2, period 1, count 10, stop at third pulse.
    cfg_delay  = 2;
    cfg_period = 1;
    cfg_count  = 10;
    run(4'b0010, 20, 6, 4'b0100);
    chk("abort_start_n", h_start_n, 64'h54);
    chk("abort_stop", h_stop, 64'h80);
    chk("abort_busy", h_busy, 64'h7F);
    chk("abort_cnt", 64'(pulse_cnt), 64'd3);
    chk("exclusive", (h_start | h_start_n) & h_stop, 64'h0);

`ifdef TR_SCHED_AUTO_EN
    // Auto mode, period 9, aborted 34 cycles in.
    cfg_delay  = 0;
    cfg_period = 9;
    run(4'b1000, 50, 34, 4'b0100);
    chk("auto_start", h_start, 64'h40100401);
    chk("auto_stop", h_stop, 64'h8_0000_0000);
    chk("auto_cnt", 64'(pulse_cnt), 64'd4);
`else
    // avto ignored when AUTO mode is not built.
    cfg_delay  = 0;
    cfg_period = 9;
    run(4'b1000, 20, 999, 4'b0000);
    chk("avto_off_start", h_start, 64'h0);
    chk("avto_off_busy", h_busy, 64'h0);
    chk("avto_off_ovr", 64'(ovr), 64'd0);
`endif

    // Reset during WAIT of a burst.
    cfg_delay   = 0;
    cfg_period  = 3;
    cfg_count   = 4;
    cmd_start_N = 1'b1;
    step();
    cmd_start_N = 1'b0;
    step();
    chk("rstmid_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    chk("rstmid_strobes", {61'd0, start, start_N, stop}, 64'd0);
    chk("rstmid_busy_ovr", {62'd0, busy, ovr}, 64'd0);
    chk("rstmid_cnt", 64'(pulse_cnt), 64'd0);
    rst = 1'b0;
    step();
    cfg_delay = 1;
    run(4'b0001, 10, 999, 4'b0000);
    chk("post_rst_start", h_start, 64'h2);
    chk("post_rst_stop", h_stop, 64'h4);
    chk("post_rst_cnt", 64'(pulse_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
